// File: rtl/synth_env_pkg.sv
// Shared types and constants for the synth envelope stage.
package synth_env_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam logic [7:0] MIDPOINT = 8'd128;

endpackage

// File: rtl/env_scaler.sv
// Combinational amplitude scaler: multiplies the offset-binary sample about its
// midpoint by the envelope level (level/256) and re-biases the result.
module env_scaler
    import synth_env_pkg::*;
(
    input  logic [7:0] sample_i,
    input  logic [7:0] level_i,
    output logic [7:0] sample_o
);

    logic signed [8:0]  s;
    logic signed [16:0] s_ext;
    logic signed [16:0] l_ext;
    logic signed [16:0] p;

    assign s     = $signed({1'b0, sample_i}) - $signed({1'b0, MIDPOINT});
    assign s_ext = {{8{s[8]}}, s};
    assign l_ext = $signed({9'd0, level_i});
    assign p     = s_ext * l_ext;

    // Arithmetic shift floors; the biased result is always 0..254.
    assign sample_o = 8'((p >>> 8) + 17'sd128);

endmodule

// File: rtl/env_adsr.sv
// ADSR envelope: gate edge detect, tick prescaler, envelope FSM and a
// registered, envelope-scaled copy of the waveshaper sample.
module env_adsr
    import synth_env_pkg::*;
#(
    parameter int TICK_DIV      = 16,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic       gate,
    input  logic       tick,
    input  logic [7:0] sample_i,
    output logic [7:0] sample_o,
    output logic [7:0] env_level,
    output logic [2:0] env_state,
    output logic       busy
);

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [8:0] ATK9      = 9'(ATTACK_STEP);
    localparam logic [8:0] DEC9      = 9'(DECAY_STEP);
    localparam logic [8:0] REL9      = 9'(RELEASE_STEP);
    localparam logic [7:0] SUS8      = 8'(SUSTAIN_LEVEL);

    env_state_t state_q, state_d;
    logic [7:0] level_q, level_d;
    logic [7:0] presc_q, presc_d;
    logic [7:0] sample_q;
    logic [7:0] scaled;
    logic       gate_q;
    logic       arm_q;
    logic       busy_q;

    logic       rise, fall, step, trans;
    logic [8:0] sum9, diff_dec9, diff_rel9;

    // A gate held across enable/reset must be seen low before it can retrigger.
    assign rise = gate & ~gate_q & arm_q;
    assign fall = ~gate & gate_q;
    assign step = tick & (presc_q == TICK_LAST);

    assign sum9      = {1'b0, level_q} + ATK9;
    assign diff_dec9 = {1'b0, level_q} - DEC9;
    assign diff_rel9 = {1'b0, level_q} - REL9;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        trans   = 1'b0;
        if (rise) begin
            state_d = ATTACK;
            trans   = 1'b1;
        end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
            trans   = 1'b1;
        end else if (step) begin
            case (state_q)
                ATTACK: begin
                    if (sum9 >= 9'd255) begin
                        level_d = 8'd255;
                        state_d = DECAY;
                    end else begin
                        level_d = sum9[7:0];
                    end
                end
                DECAY: begin
                    if (diff_dec9[8] || diff_dec9[7:0] <= SUS8) begin
                        level_d = SUS8;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = diff_dec9[7:0];
                    end
                end
                RELEASE: begin
                    if (diff_rel9[8] || diff_rel9[7:0] == 8'd0) begin
                        level_d = 8'd0;
                        state_d = IDLE;
                    end else begin
                        level_d = diff_rel9[7:0];
                    end
                end
                IDLE:    level_d = 8'd0;
                default: level_d = level_q;
            endcase
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (trans) begin
            presc_d = 8'd0;
        end else if (tick) begin
            presc_d = step ? 8'd0 : presc_q + 8'd1;
        end
    end

    env_scaler u_scaler (
        .sample_i (sample_i),
        .level_i  (level_q),
        .sample_o (scaled)
    );

    always_ff @(posedge clk) begin
        if (!n_rst || !en) begin
            state_q  <= IDLE;
            level_q  <= 8'd0;
            presc_q  <= 8'd0;
            gate_q   <= 1'b0;
            arm_q    <= 1'b0;
            busy_q   <= 1'b0;
            sample_q <= MIDPOINT;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            presc_q  <= presc_d;
            gate_q   <= gate;
            arm_q    <= arm_q | ~gate;
            busy_q   <= (state_d != IDLE);
            sample_q <= scaled;
        end
    end

    assign sample_o  = sample_q;
    assign env_level = level_q;
    assign env_state = state_q;
    assign busy      = busy_q;

endmodule
